// File: rtl/wired_rf_pkg.sv
// rtl/wired_rf_pkg.sv - shared register-file write types and helpers
package wired_rf_pkg;

    localparam int RF_ADDR_W  = 5;
    localparam int RF_ENTRIES = 32;

    // Write request tag; data travels alongside because its width is a module parameter
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
    } rf_wr_req_t;

    // One-hot decode of a register address
    function automatic logic [RF_ENTRIES-1:0] rf_decode(input logic [RF_ADDR_W-1:0] a);
        logic [RF_ENTRIES-1:0] one;
        one = {{(RF_ENTRIES-1){1'b0}}, 1'b1};
        return one << a;
    endfunction

endpackage

// File: rtl/wired_rf_wr_fifo.sv
// rtl/wired_rf_wr_fifo.sv - 2-push/1-pop in-order buffer of register writes
module wired_rf_wr_fifo
    import wired_rf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0,
    input  logic [RF_ADDR_W-1:0]       push0_addr,
    input  logic [WIDTH-1:0]           push0_data,
    input  logic                       push1,
    input  logic [RF_ADDR_W-1:0]       push1_addr,
    input  logic [WIDTH-1:0]           push1_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic [RF_ADDR_W-1:0]       head_addr,
    output logic [WIDTH-1:0]           head_data,
    output logic [DEPTH-1:0]           valid_vec,
    output rf_wr_req_t [DEPTH-1:0]     entry_req
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    rf_wr_req_t       req_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    // The first free slot takes port 0 when it pushes, otherwise port 1
    logic [RF_ADDR_W-1:0] slot0_addr;
    logic [WIDTH-1:0]     slot0_data;
    logic [PW-1:0]        slot1_ptr;

    assign slot0_addr = push0 ? push0_addr : push1_addr;
    assign slot0_data = push0 ? push0_data : push1_data;
    assign slot1_ptr  = wr_ptr + PW'(1);

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr <= rd_ptr + PW'(pop);
            cnt_q  <= cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // Entry storage needs no reset; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (push0 || push1) begin
            req_mem[wr_ptr].addr <= slot0_addr;
            data_mem[wr_ptr]     <= slot0_data;
        end
        if (push0 && push1) begin
            req_mem[slot1_ptr].addr <= push1_addr;
            data_mem[slot1_ptr]     <= push1_data;
        end
    end

    assign cnt       = cnt_q;
    assign head_addr = req_mem[rd_ptr].addr;
    assign head_data = data_mem[rd_ptr];

    // Slot i holds a live entry when its distance past the read pointer is below cnt
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PW-1:0] offset;
        assign offset       = PW'(i) - rd_ptr;
        assign valid_vec[i] = ({1'b0, offset} < cnt_q);
        assign entry_req[i] = req_mem[i];
    end

endmodule

// File: rtl/wired_rf_wr_merge.sv
// rtl/wired_rf_wr_merge.sv - merges two writeback ports onto the RAM write port (optional WIRED_RF_WR_PEND_EN)
module wired_rf_wr_merge
    import wired_rf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in0_valid,
    output logic                     in0_ready,
    input  logic [RF_ADDR_W-1:0]     in0_addr,
    input  logic [WIDTH-1:0]         in0_data,
    input  logic                     in1_valid,
    output logic                     in1_ready,
    input  logic [RF_ADDR_W-1:0]     in1_addr,
    input  logic [WIDTH-1:0]         in1_data,
    output logic                     wea,
    output logic [RF_ADDR_W-1:0]     addrw,
    output logic [WIDTH-1:0]         din,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic [RF_ENTRIES-1:0]    pend_mask
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                   push0;
    logic                   push1;
    logic                   pop;
    logic [CW-1:0]          fifo_cnt;
    logic [DEPTH-1:0]       valid_vec;
    rf_wr_req_t [DEPTH-1:0] entry_req;

    // Readiness looks only at the registered occupancy, never at valid or the pop
    assign in0_ready = !rst && (fifo_cnt < CW'(DEPTH));
    assign in1_ready = !rst && (fifo_cnt < CW'(DEPTH - 1));

    assign push0 = in0_valid && in0_ready;
    assign push1 = in1_valid && in1_ready;

    // The RAM takes one write every cycle, so a non-empty buffer always pops
    assign wea = !rst && (fifo_cnt != '0);
    assign pop = wea;
    assign cnt = fifo_cnt;

    wired_rf_wr_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push0      (push0),
        .push0_addr (in0_addr),
        .push0_data (in0_data),
        .push1      (push1),
        .push1_addr (in1_addr),
        .push1_data (in1_data),
        .pop        (pop),
        .cnt        (fifo_cnt),
        .head_addr  (addrw),
        .head_data  (din),
        .valid_vec  (valid_vec),
        .entry_req  (entry_req)
    );

`ifdef WIRED_RF_WR_PEND_EN
    // Pending set is the OR of address decodes across every live entry
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_vec[i]) begin
                pend_mask = pend_mask | rf_decode(entry_req[i].addr);
            end
        end
    end
`else
    logic unused_pend_src;
    assign unused_pend_src = ^{valid_vec, entry_req};
    assign pend_mask       = '0;
`endif

endmodule

// File: tb/tb_wired_rf_wr_merge.sv
// tb/tb_wired_rf_wr_merge.sv - self-checking bench for the writeback merge front end
module tb_wired_rf_wr_merge;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk;
    logic          rst;
    logic          in0_valid;
    logic          in0_ready;
    logic [4:0]    in0_addr;
    logic [W-1:0]  in0_data;
    logic          in1_valid;
    logic          in1_ready;
    logic [4:0]    in1_addr;
    logic [W-1:0]  in1_data;
    logic          wea;
    logic [4:0]    addrw;
    logic [W-1:0]  din;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_mask;

    wired_rf_wr_merge #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_addr  (in0_addr),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_addr  (in1_addr),
        .in1_data  (in1_data),
        .wea       (wea),
        .addrw     (addrw),
        .din       (din),
        .cnt       (cnt),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   a;
        logic [W-1:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t acc[$];
    ent_t obs[$];
    bit   rec;
    int   checks;
    int   errors;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: an ordered queue of pending writes
    int   m_sz;
    ent_t m_e;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_sz = mq.size();
            if (m_sz > 0) void'(mq.pop_front());
            if (in0_valid && (m_sz < D)) begin
                m_e.a = in0_addr; m_e.d = in0_data;
                mq.push_back(m_e);
                if (rec) acc.push_back(m_e);
            end
            if (in1_valid && (m_sz <= D - 2)) begin
                m_e.a = in1_addr; m_e.d = in1_data;
                mq.push_back(m_e);
                if (rec) acc.push_back(m_e);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    logic        e_wea;
    logic [31:0] e_pend;
    ent_t        o_e;
    always @(negedge clk) begin
        e_wea = !rst && (mq.size() > 0);
        chk("wea", 64'(wea), 64'(e_wea));
        chk("cnt", 64'(cnt), 64'(mq.size()));
        chk("in0_ready", 64'(in0_ready), 64'(!rst && (mq.size() < D)));
        chk("in1_ready", 64'(in1_ready), 64'(!rst && (mq.size() <= D - 2)));
        if (e_wea) begin
            chk("addrw", 64'(addrw), 64'(mq[0].a));
            chk("din", 64'(din), 64'(mq[0].d));
        end
        e_pend = '0;
`ifdef WIRED_RF_WR_PEND_EN
        foreach (mq[i]) e_pend[mq[i].a] = 1'b1;
`endif
        chk("pend_mask", 64'(pend_mask), 64'(e_pend));
        if (rec && wea === 1'b1) begin
            o_e.a = addrw; o_e.d = din;
            obs.push_back(o_e);
        end
    end

    task automatic cyc(input logic v0, input logic [4:0] a0, input logic [W-1:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [W-1:0] d1);
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic cmp_streams(input string nm, input int n_exp);
        chk({nm, "_acc_n"}, 64'(acc.size()), 64'(n_exp));
        chk({nm, "_obs_n"}, 64'(obs.size()), 64'(acc.size()));
        for (int i = 0; i < acc.size() && i < obs.size(); i++) begin
            chk({nm, "_addr"}, 64'(obs[i].a), 64'(acc[i].a));
            chk({nm, "_data"}, 64'(obs[i].d), 64'(acc[i].d));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rec = 1'b0;
        rst = 1'b1;
        in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
        in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
        idle(2);
        chk("rst_wea", 64'(wea), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_rdy0", 64'(in0_ready), 64'd0);
        chk("rst_rdy1", 64'(in1_ready), 64'd0);
        rst = 1'b0;
        idle(1);
        chk("rel_rdy0", 64'(in0_ready), 64'd1);
        chk("rel_rdy1", 64'(in1_ready), 64'd1);

        // Single write, one cycle latency
        cyc(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, '0);
        chk("t1_wea", 64'(wea), 64'd1);
        chk("t1_addr", 64'(addrw), 64'd3);
        chk("t1_din", 64'(din), 64'hA5A5A5A5);
        idle(1);
        chk("t1_wea_off", 64'(wea), 64'd0);
        chk("t1_cnt", 64'(cnt), 64'd0);

        // Both ports every cycle
        acc.delete(); obs.delete(); rec = 1'b1;
        cyc(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h201);
        chk("t2_cnt2", 64'(cnt), 64'd2);
        cyc(1'b1, 5'd1, 32'h102, 1'b1, 5'd2, 32'h202);
        chk("t2_cnt3", 64'(cnt), 64'd3);
        chk("t2_rdy1_low", 64'(in1_ready), 64'd0);
        chk("t2_rdy0_high", 64'(in0_ready), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd1, 32'h110 + i, 1'b1, 5'd2, 32'h210 + i);
        idle(5);
        rec = 1'b0;
        chk("t2_w0", 64'(obs[0].a), 64'd1);
        chk("t2_w1", 64'(obs[1].a), 64'd2);
        chk("t2_w2", 64'(obs[2].a), 64'd1);
        chk("t2_w3", 64'(obs[3].a), 64'd2);
        cmp_streams("t2", 8);

        // Same address from both ports
        cyc(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        chk("t3_a0", 64'(addrw), 64'd7);
        chk("t3_d0", 64'(din), 64'h11);
        idle(1);
        chk("t3_wea1", 64'(wea), 64'd1);
        chk("t3_a1", 64'(addrw), 64'd7);
        chk("t3_d1", 64'(din), 64'h22);
        idle(1);
        chk("t3_done", 64'(wea), 64'd0);

        // Reset with a loaded buffer
        cyc(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB);
        cyc(1'b1, 5'd12, 32'hCC, 1'b1, 5'd13, 32'hDD);
        chk("t4_cnt", 64'(cnt), 64'd3);
        in0_valid = 1'b0; in1_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t4_wea_in_rst", 64'(wea), 64'd0);
        idle(1);
        chk("t4_wea", 64'(wea), 64'd0);
        chk("t4_cnt0", 64'(cnt), 64'd0);
        chk("t4_rdy0_rst", 64'(in0_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("t4_rdy0", 64'(in0_ready), 64'd1);
        chk("t4_rdy1", 64'(in1_ready), 64'd1);
        idle(2);
        chk("t4_nowrite", 64'(wea), 64'd0);

        // Wrap: single pushes with random gaps
        acc.delete(); obs.delete(); rec = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0)
                cyc(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b0, 5'd0, '0);
            else
                cyc(1'b0, 5'd0, '0, 1'b1, 5'($urandom_range(0, 31)), $urandom);
            idle($urandom_range(0, 2));
        end
        idle(4);
        rec = 1'b0;
        cmp_streams("t5", 20);

        // Pending mask
        cyc(1'b1, 5'd5, 32'h55, 1'b1, 5'd9, 32'h99);
`ifdef WIRED_RF_WR_PEND_EN
        chk("t6_pend_both", 64'(pend_mask), 64'h220);
        idle(1);
        chk("t6_pend_9", 64'(pend_mask), 64'h200);
        idle(1);
        chk("t6_pend_none", 64'(pend_mask), 64'h0);
`else
        chk("t6_pend_off", 64'(pend_mask), 64'h0);
        idle(2);
`endif
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
